data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 137 +++++++++++++
 tb/tb_data_mem_resp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// 256x16 data memory with post-reset clear sweep, CPU port and host preload port.
// Define DMEM_PARITY_EN to store an even-parity bit per word and flag read errors.
//   state    | meaning
//   ST_CLEAR | sweeping CLEAR_VAL into every word, ports ignored
//   ST_SERVE | serving CPU reads/writes and host preloads (terminal)
module data_mem_resp #(
    parameter logic [15:0] CLEAR_VAL = 16'h0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  d_addr,
    input  logic [15:0] d_dataout,
    input  logic        d_we,
    output logic [15:0] d_datain,
    input  logic        ld_valid,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic        init_done,
    output logic        parity_err
);

`ifdef DMEM_PARITY_EN
    localparam int W = 17;
`else
    localparam int W = 16;
`endif

    typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    clr_cnt_q, clr_cnt_d;
    logic          init_done_q, init_done_d;
    logic [15:0]   d_datain_q, d_datain_d;
    logic          mem_we;
    logic [7:0]    mem_waddr;
    logic [15:0]   mem_wdata;
    logic [W-1:0]  mem_word;
    logic [W-1:0]  rd_word;
    logic          rd_chk;
    logic [W-1:0]  mem_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= 8'h00;
            init_done_q <= 1'b0;
            d_datain_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            d_datain_q  <= d_datain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == 8'hFF) state_d = ST_SERVE;
            ST_SERVE: state_d = ST_SERVE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    assign ld_ready = init_done_q & ~d_we;
    assign rd_word  = mem_q[d_addr];

    // init_done lags the SERVE transition by one edge; servicing is gated on it
    always_comb begin
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        d_datain_d  = 16'h0000;
        mem_we      = 1'b0;
        mem_waddr   = clr_cnt_q;
        mem_wdata   = CLEAR_VAL;
        rd_chk      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clr_cnt_q != 8'hFF) clr_cnt_d = clr_cnt_q + 8'h01;
            end
            ST_SERVE: begin
                init_done_d = 1'b1;
                if (init_done_q) begin
                    d_datain_d = rd_word[15:0];
                    rd_chk     = 1'b1;
                    if (d_we) begin
                        mem_we     = 1'b1;
                        mem_waddr  = d_addr;
                        mem_wdata  = d_dataout;
                        d_datain_d = d_dataout;
                        rd_chk     = 1'b0;
                    end else if (ld_valid) begin
                        mem_we    = 1'b1;
                        mem_waddr = ld_addr;
                        mem_wdata = ld_data;
                        if (ld_addr == d_addr) begin
                            d_datain_d = ld_data;
                            rd_chk     = 1'b0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef DMEM_PARITY_EN
    logic parity_err_q;

    assign mem_word = {^mem_wdata, mem_wdata};

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       parity_err_q <= 1'b0;
        else if (rd_chk && (^rd_word))   parity_err_q <= 1'b1;
    end

    assign parity_err = parity_err_q;
`else
    assign mem_word   = mem_wdata;
    assign parity_err = 1'b0;

    logic unused_rd_chk;
    assign unused_rd_chk = rd_chk;
`endif

    // storage is initialized by the sweep, not by reset
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_word;
    end

    assign d_datain  = d_datain_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp; parity scenario runs when DMEM_PARITY_EN is defined.
module tb_data_mem_resp;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        init_done;
    logic        parity_err;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_resp dut (
        .clock      (clock),
        .reset      (reset),
        .d_addr     (d_addr),
        .d_dataout  (d_dataout),
        .d_we       (d_we),
        .d_datain   (d_datain),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .init_done  (init_done),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_datain", {16'h0, d_datain}, 32'h0);
        chk("rst_init_done", {31'h0, init_done}, 32'h0);
        chk("rst_parity_err", {31'h0, parity_err}, 32'h0);
        chk("rst_clr_cnt", {24'h0, dut.clr_cnt_q}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        d_addr    = 8'h00;
        d_dataout = 16'h0000;
        d_we      = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = 8'h00;
        ld_data   = 16'h0000;
        #12;
        do_reset();

        // clear sweep: CPU write and host request must be ignored
        tick(10);
        d_we = 1'b1; d_addr = 8'h50; d_dataout = 16'hDEAD;
        tick(1);
        chk("clr_datain_zero", {16'h0, d_datain}, 32'h0);
        d_we = 1'b0; ld_valid = 1'b1; ld_addr = 8'h60; ld_data = 16'h5555;
        #1;
        chk("clr_ld_ready_low", {31'h0, ld_ready}, 32'h0);
        ld_valid = 1'b0;
        tick(245);
        chk("init_done_edge256", {31'h0, init_done}, 32'h0);
        tick(1);
        chk("init_done_edge257", {31'h0, init_done}, 32'h1);
        chk("ld_ready_serve", {31'h0, ld_ready}, 32'h1);

        d_addr = 8'h00;
        tick(1);
        chk("rd_00_cleared", {16'h0, d_datain}, 32'h0);
        d_addr = 8'hFF;
        tick(1);
        chk("rd_ff_cleared", {16'h0, d_datain}, 32'h0);
        d_addr = 8'h50;
        tick(1);
        chk("rd_50_not_written", {16'h0, d_datain}, 32'h0);

        // CPU write-through then read back
        d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hA5A5;
        #1;
        chk("ld_ready_cpu_we", {31'h0, ld_ready}, 32'h0);
        tick(1);
        chk("wr_through", {16'h0, d_datain}, 32'hA5A5);
        d_we = 1'b0;
        tick(1);
        chk("rd_after_wr", {16'h0, d_datain}, 32'hA5A5);
        d_addr = 8'h00;
        #1;
        chk("rd_registered", {16'h0, d_datain}, 32'hA5A5);
        tick(1);
        chk("rd_latency1", {16'h0, d_datain}, 32'h0);

        // host request held pending behind CPU writes
        ld_valid = 1'b1; ld_addr = 8'h20; ld_data = 16'h1234;
        d_we = 1'b1; d_addr = 8'h11; d_dataout = 16'h0001;
        #1;
        chk("ld_pend_c1", {31'h0, ld_ready}, 32'h0);
        tick(1);
        chk("ld_pend_c2", {31'h0, ld_ready}, 32'h0);
        tick(1);
        d_we = 1'b0; d_addr = 8'h10;
        #1;
        chk("ld_accept", {31'h0, ld_ready}, 32'h1);
        tick(1);
        chk("rd_10_during_ld", {16'h0, d_datain}, 32'hA5A5);
        ld_valid = 1'b0; d_addr = 8'h20;
        tick(1);
        chk("rd_20_preload", {16'h0, d_datain}, 32'h1234);
        d_addr = 8'h11;
        tick(1);
        chk("rd_11_cpu", {16'h0, d_datain}, 32'h0001);

        // same-cycle host write and CPU read of that address
        ld_valid = 1'b1; ld_addr = 8'h30; ld_data = 16'hBEEF; d_addr = 8'h30;
        tick(1);
        chk("bypass_30", {16'h0, d_datain}, 32'hBEEF);
        ld_addr = 8'h31; ld_data = 16'h7777;
        tick(1);
        chk("no_bypass_31", {16'h0, d_datain}, 32'hBEEF);
        ld_valid = 1'b0; d_addr = 8'h31;
        tick(1);
        chk("rd_31", {16'h0, d_datain}, 32'h7777);

`ifdef DMEM_PARITY_EN
        d_addr = 8'h41;
        tick(1);
        chk("par_clean", {31'h0, parity_err}, 32'h0);
        dut.mem_q[8'h40] = dut.mem_q[8'h40] ^ 17'h10000;
        d_addr = 8'h40;
        tick(1);
        chk("par_err_set", {31'h0, parity_err}, 32'h1);
        d_addr = 8'h00;
        tick(3);
        chk("par_err_sticky", {31'h0, parity_err}, 32'h1);
`else
        chk("par_tied_low", {31'h0, parity_err}, 32'h0);
`endif

        // reset mid-sweep restarts from address 0
        do_reset();
        tick(100);
        chk("clr_cnt_100", {24'h0, dut.clr_cnt_q}, 32'd100);
        do_reset();
        tick(256);
        chk("restart_edge256", {31'h0, init_done}, 32'h0);
        tick(1);
        chk("restart_edge257", {31'h0, init_done}, 32'h1);
        d_addr = 8'h10;
        tick(1);
        chk("rd_10_recleared", {16'h0, d_datain}, 32'h0);
        d_addr = 8'h20;
        tick(1);
        chk("rd_20_recleared", {16'h0, d_datain}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
